fir_channel_scheduler: RTL and testbench
========================================

# fir_channel_scheduler

Round-robin scheduler that shares one FIR filter core among `NUM_CH` deserializer channels. Each channel presents a parallel word (as produced by the deserializer FSM). The scheduler grants one channel at a time, issues the word to the core, waits for the filtered result, and returns it tagged with the channel index. It sits between the per-channel deserializers and the downstream serializer/output stage.

## Interface
- `NUM_CH`, 4: number of requesting channels (2..8)
- `WIDTH`, 24: sample/word width in bits
- `TIMEOUT`, 255: max cycles in WAIT before abort (used only with the watchdog macro)
- `CH_W`: local parameter, `$clog2(NUM_CH)`

Ports:
- `i_clk` in 1: clock, all logic on rising edge
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_en` in 1: enables new grants; an in-flight transaction always completes
- `iv_req_valid` in NUM_CH: channel k holds a valid word
- `iv_req_data` in NUM_CH*WIDTH: channel k word at bits [k*WIDTH +: WIDTH]
- `ov_req_ready` out NUM_CH: one-hot accept; word k is consumed in the cycle where bit k is high with valid
- `ov_core_din` out WIDTH: sample to FIR core
- `o_core_din_valid` out 1: sample valid to core
- `i_core_ready` in 1: core accepts sample
- `iv_core_dout` in WIDTH: core result
- `i_core_dout_valid` in 1: core result valid
- `o_core_ready` out 1: scheduler accepts result
- `ov_dout` out WIDTH: result to downstream
- `ov_dout_ch` out CH_W: channel index of `ov_dout`
- `o_dout_valid` out 1: result valid
- `i_dout_ready` in 1: downstream consumes result
- `o_busy` out 1: state != IDLE
- `o_timeout` out 1: sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- **IDLE:**
  - If `i_en` and any `iv_req_valid` bit is set, select the first valid channel searching from `last+1` mod NUM_CH.
  - Drive `ov_req_ready[sel]`=1 combinationally in that cycle. Capture the data and `sel`, then go to ISSUE.
  - Otherwise `ov_req_ready` is 0.
- **ISSUE:** `o_core_din_valid`=1 and `ov_core_din`=captured word, held stable. On `i_core_ready`, go to WAIT.
- **WAIT:** `o_core_ready`=1. On `i_core_dout_valid`, capture `iv_core_dout` and go to DELIVER.
- **DELIVER:**
  - `o_dout_valid`=1, with `ov_dout` and `ov_dout_ch` stable.
  - On `i_dout_ready`, set `last`=sel and go to IDLE.
- Round-robin is strictly fair: a continuously requesting channel waits at most NUM_CH-1 transactions.
- `ov_req_ready` is never asserted outside IDLE and is never multi-hot.
- `i_core_dout_valid` outside WAIT is ignored. `i_core_ready` outside ISSUE is ignored.
- `i_en` deasserted in IDLE: no grant. Deasserted in any other state: the transaction continues to DELIVER completion.
- Simultaneous requests in the same cycle are resolved by the rotating pointer only. Request order is not considered.

## Timing
- Reset (`i_rst_n`=0, async):
  - State IDLE, `last`=NUM_CH-1, so channel 0 has first priority.
  - All outputs 0, `o_timeout`=0.
  - Capture registers cleared.
- Reset mid-transaction aborts it. Nothing is delivered, and no result is replayed after reset.
- Grant to `o_core_din_valid`: 1 cycle.
- Best case, with `i_core_ready` high in the first ISSUE cycle and `i_core_dout_valid` high in the first WAIT cycle: `o_dout_valid` rises 3 cycles after the grant cycle.
- Back-to-back: the next grant can occur in the cycle after the DELIVER handshake. Minimum period is 4 cycles per transaction.
- All outputs are registered except `ov_req_ready`, `o_core_ready`, and `o_busy`, which decode the registered state.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - Cycle counter runs in WAIT and is cleared on entry to WAIT.
  - If it reaches `TIMEOUT` without `i_core_dout_valid`, set `o_timeout`=1 (sticky until reset), drop the transaction, advance `last`=sel, and return to IDLE without asserting `o_dout_valid`.
- `SCHED_TIMEOUT_EN` undefined:
  - WAIT persists indefinitely.
  - `o_timeout` is tied to 0 and no counter is synthesized.

## Test plan
- Reset then single request: ch2 valid with data 0xABCDEF; core echoes in 1 cycle -> `ov_req_ready`=0b0100 for one cycle, `ov_dout`=0xABCDEF, `ov_dout_ch`=2, `o_dout_valid` 3 cycles after grant.
- All 4 channels valid continuously with distinct words -> grant order 0,1,2,3,0,…. Each result tagged with the correct channel; no channel is granted twice in any 4 consecutive grants.
- Backpressure: hold `i_core_ready`=0 for 5 cycles, then `i_dout_ready`=0 for 7 cycles -> `ov_core_din`/`o_core_din_valid` and then `ov_dout`/`o_dout_valid` stay stable; no new grant until the handshake completes.
- `i_en` dropped in ISSUE -> the transaction completes and is delivered, then no further grants while `i_en`=0 despite pending valids.
- `i_rst_n` pulsed low in WAIT -> all outputs 0 immediately. After release, ch0 is granted first, and the stale core result is not delivered.
- With `SCHED_TIMEOUT_EN` and `TIMEOUT`=16, the core never responds -> after 16 WAIT cycles `o_timeout`=1, FSM returns to IDLE, the next channel is granted, and `o_dout_valid` never asserts for the dropped word.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR core among NUM_CH channels; results are returned tagged with the channel.
// Optional WAIT watchdog is enabled by defining SCHED_TIMEOUT_EN.
module fir_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 24,
  parameter int TIMEOUT = 255,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [NUM_CH-1:0]       iv_req_valid,
  input  logic [NUM_CH*WIDTH-1:0] iv_req_data,
  output logic [NUM_CH-1:0]       ov_req_ready,
  output logic [WIDTH-1:0]        ov_core_din,
  output logic                    o_core_din_valid,
  input  logic                    i_core_ready,
  input  logic [WIDTH-1:0]        iv_core_dout,
  input  logic                    i_core_dout_valid,
  output logic                    o_core_ready,
  output logic [WIDTH-1:0]        ov_dout,
  output logic [CH_W-1:0]         ov_dout_ch,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready,
  output logic                    o_busy,
  output logic                    o_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              din_valid_q, din_valid_d;
  logic              dout_valid_q, dout_valid_d;

  logic [WIDTH-1:0]  req_word [NUM_CH];
  logic [NUM_CH-1:0] grant_c;
  logic [CH_W-1:0]   pick_c;
  logic [CH_W-1:0]   idx_c;
  logic              found_c;

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign req_word[gi] = iv_req_data[gi*WIDTH +: WIDTH];
  end

  // Rotating search: first valid channel starting just after the last served one.
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_c = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!found_c && iv_req_valid[idx_c]) begin
        found_c = 1'b1;
        pick_c  = idx_c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    din_d   = din_q;
    dout_d  = dout_q;
    grant_c = '0;
`ifdef SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_en && found_c) begin
          grant_c[pick_c] = 1'b1;
          sel_d           = pick_c;
          din_d           = req_word[pick_c];
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_core_ready) begin
          state_d = S_WAIT;
`ifdef SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (i_core_dout_valid) begin
          dout_d  = iv_core_dout;
          state_d = S_DELIVER;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Drop the word but still advance the pointer so the stuck channel loses its turn.
          timeout_d = 1'b1;
          last_d    = sel_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DELIVER: begin
        if (i_dout_ready) begin
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    din_valid_d  = (state_d == S_ISSUE);
    dout_valid_d = (state_d == S_DELIVER);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      last_q       <= CH_W'(NUM_CH - 1);
      sel_q        <= '0;
      din_q        <= '0;
      dout_q       <= '0;
      din_valid_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sel_q        <= sel_d;
      din_q        <= din_d;
      dout_q       <= dout_d;
      din_valid_q  <= din_valid_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  // Gated by reset so a pending request cannot show a grant while held in reset.
  assign ov_req_ready     = i_rst_n ? grant_c : '0;
  assign ov_core_din      = din_q;
  assign o_core_din_valid = din_valid_q;
  assign o_core_ready     = (state_q == S_WAIT);
  assign ov_dout          = dout_q;
  assign ov_dout_ch       = sel_q;
  assign o_dout_valid     = dout_valid_q;
  assign o_busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed testbench for fir_channel_scheduler: one task per scenario, inline checks, one summary line.
module tb_fir_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 24;
  localparam int CH_W   = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic                    i_en;
  logic [NUM_CH-1:0]       iv_req_valid;
  logic [NUM_CH*WIDTH-1:0] iv_req_data;
  logic [NUM_CH-1:0]       ov_req_ready;
  logic [WIDTH-1:0]        ov_core_din;
  logic                    o_core_din_valid;
  logic                    i_core_ready;
  logic [WIDTH-1:0]        iv_core_dout;
  logic                    i_core_dout_valid;
  logic                    o_core_ready;
  logic [WIDTH-1:0]        ov_dout;
  logic [CH_W-1:0]         ov_dout_ch;
  logic                    o_dout_valid;
  logic                    i_dout_ready;
  logic                    o_busy;
  logic                    o_timeout;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH-1:0] words [NUM_CH] = '{24'hA00001, 24'hB10002, 24'hC20003, 24'hD30004};

  always #5 i_clk = ~i_clk;

  fir_channel_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .iv_req_valid(iv_req_valid), .iv_req_data(iv_req_data), .ov_req_ready(ov_req_ready),
    .ov_core_din(ov_core_din), .o_core_din_valid(o_core_din_valid), .i_core_ready(i_core_ready),
    .iv_core_dout(iv_core_dout), .i_core_dout_valid(i_core_dout_valid), .o_core_ready(o_core_ready),
    .ov_dout(ov_dout), .ov_dout_ch(ov_dout_ch), .o_dout_valid(o_dout_valid),
    .i_dout_ready(i_dout_ready), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  // One step: just after the next falling edge, well away from the rising edge.
  task automatic cyc();
    @(negedge i_clk);
    #1;
  endtask

  task automatic load_words();
    iv_req_data = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ov_req_ready, ov_core_din, o_core_din_valid, o_core_ready, ov_dout, ov_dout_ch,
         o_dout_valid, o_busy, o_timeout} !== '0) begin
      failures++;
      $display("FAIL %s_outputs_zero: got req=%b din=%h dinv=%b crdy=%b dout=%h ch=%0d dv=%b busy=%b to=%b required all 0",
               tag, ov_req_ready, ov_core_din, o_core_din_valid, o_core_ready, ov_dout, ov_dout_ch,
               o_dout_valid, o_busy, o_timeout);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_en = 1'b1; iv_req_valid = 4'hF; load_words();
    i_core_ready = 1'b1; iv_core_dout = 24'h111111; i_core_dout_valid = 1'b1; i_dout_ready = 1'b1;
    cyc();
    check_all_zero("reset");
    i_en = 1'b0; iv_req_valid = '0; i_core_dout_valid = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    cyc();
    check_all_zero("after_release");
    $display("reset: outputs checked in and after reset");
  endtask

  task automatic test_single();
    iv_req_data[2*WIDTH +: WIDTH] = 24'hABCDEF;
    iv_req_valid = 4'b0100; i_en = 1'b1; i_core_ready = 1'b1; i_dout_ready = 1'b1;
    i_core_dout_valid = 1'b0;
    #1;
    checks++;
    if (ov_req_ready !== 4'b0100) begin
      failures++; $display("FAIL single_grant: got %b required 0100", ov_req_ready);
    end
    cyc();
    iv_req_valid = '0; iv_core_dout = 24'hABCDEF; i_core_dout_valid = 1'b1;
    #1;
    checks++;
    if ({ov_req_ready, o_core_din_valid, ov_core_din} !== {4'b0000, 1'b1, 24'hABCDEF}) begin
      failures++; $display("FAIL single_issue: got req=%b v=%b din=%h required 0000/1/abcdef",
                           ov_req_ready, o_core_din_valid, ov_core_din);
    end
    cyc();
    checks++;
    if ({o_core_ready, o_dout_valid, o_core_din_valid} !== 3'b100) begin
      failures++; $display("FAIL single_wait: got crdy=%b dv=%b dinv=%b required 1/0/0",
                           o_core_ready, o_dout_valid, o_core_din_valid);
    end
    cyc();
    i_core_dout_valid = 1'b0;
    checks++;
    if ({o_dout_valid, ov_dout, ov_dout_ch} !== {1'b1, 24'hABCDEF, 2'd2}) begin
      failures++; $display("FAIL single_deliver: got dv=%b dout=%h ch=%0d required 1/abcdef/2",
                           o_dout_valid, ov_dout, ov_dout_ch);
    end
    cyc();
    checks++;
    if ({o_dout_valid, o_busy} !== 2'b00) begin
      failures++; $display("FAIL single_done: got dv=%b busy=%b required 0/0", o_dout_valid, o_busy);
    end
    $display("single: ch2 word abcdef delivered 3 cycles after grant");
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int delivers = 0;
    int last_grant = -1;
    int exp_ch;
    logic [NUM_CH-1:0] exp_grant;
    load_words();
    iv_req_valid = 4'hF; i_en = 1'b1; i_core_ready = 1'b1; i_core_dout_valid = 1'b1; i_dout_ready = 1'b1;
    for (int c = 0; c < 60 && delivers < 8; c++) begin
      iv_core_dout = ov_core_din;
      #1;
      if (ov_req_ready !== '0) begin
        exp_ch = (3 + grants) % NUM_CH;
        exp_grant = 4'b0001 << exp_ch;
        checks++;
        if (ov_req_ready !== exp_grant) begin
          failures++; $display("FAIL rr_grant: grant #%0d got %b required %b", grants, ov_req_ready, exp_grant);
        end
        if (grants > 0) begin
          checks++;
          if (c - last_grant != 4) begin
            failures++; $display("FAIL rr_period: got %0d cycles required 4", c - last_grant);
          end
        end
        last_grant = c;
        grants++;
      end
      if (o_dout_valid === 1'b1) begin
        exp_ch = (3 + delivers) % NUM_CH;
        checks++;
        if ({ov_dout_ch, ov_dout} !== {CH_W'(exp_ch), words[exp_ch]}) begin
          failures++; $display("FAIL rr_result: got ch=%0d data=%h required ch=%0d data=%h",
                               ov_dout_ch, ov_dout, exp_ch, words[exp_ch]);
        end
        $display("round_robin: result %0d ch=%0d data=%h", delivers, ov_dout_ch, ov_dout);
        delivers++;
        if (delivers == 8) iv_req_valid = '0;
      end
      cyc();
    end
    i_core_dout_valid = 1'b0;
    checks++;
    if (delivers != 8 || o_busy !== 1'b0) begin
      failures++; $display("FAIL rr_count: got %0d results busy=%b required 8 and idle", delivers, o_busy);
    end
  endtask

  task automatic test_backpressure();
    iv_req_valid = 4'hF; i_en = 1'b1; i_core_ready = 1'b0; i_core_dout_valid = 1'b0; i_dout_ready = 1'b0;
    #1;
    checks++;
    if (ov_req_ready !== 4'b1000) begin
      failures++; $display("FAIL bp_grant: got %b required 1000", ov_req_ready);
    end
    cyc();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({o_core_din_valid, ov_core_din, ov_req_ready} !== {1'b1, words[3], 4'b0000}) begin
        failures++; $display("FAIL bp_issue_hold: cycle %0d got v=%b din=%h req=%b required 1/%h/0000",
                             i, o_core_din_valid, ov_core_din, ov_req_ready, words[3]);
      end
      cyc();
    end
    i_core_ready = 1'b1;
    cyc();
    i_core_ready = 1'b0; iv_core_dout = 24'h5A5A5A; i_core_dout_valid = 1'b1;
    cyc();
    i_core_dout_valid = 1'b0; iv_core_dout = 24'h123456;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++;
      if ({o_dout_valid, ov_dout, ov_dout_ch, ov_req_ready} !== {1'b1, 24'h5A5A5A, 2'd3, 4'b0000}) begin
        failures++; $display("FAIL bp_deliver_hold: cycle %0d got dv=%b dout=%h ch=%0d req=%b required 1/5a5a5a/3/0000",
                             i, o_dout_valid, ov_dout, ov_dout_ch, ov_req_ready);
      end
      cyc();
    end
    i_dout_ready = 1'b1; iv_req_valid = '0;
    cyc();
    checks++;
    if ({o_dout_valid, o_busy} !== 2'b00) begin
      failures++; $display("FAIL bp_release: got dv=%b busy=%b required 0/0", o_dout_valid, o_busy);
    end
    $display("backpressure: ch3 held 5 issue cycles and 7 deliver cycles");
  endtask

  task automatic test_enable_drop();
    iv_req_valid = 4'b0011; i_en = 1'b1; i_core_ready = 1'b0; i_dout_ready = 1'b1; i_core_dout_valid = 1'b0;
    #1;
    checks++;
    if (ov_req_ready !== 4'b0001) begin
      failures++; $display("FAIL en_grant: got %b required 0001", ov_req_ready);
    end
    cyc();
    i_en = 1'b0; i_core_ready = 1'b1;
    cyc();
    i_core_ready = 1'b0; iv_core_dout = 24'h0F0F0F; i_core_dout_valid = 1'b1;
    cyc();
    i_core_dout_valid = 1'b0;
    checks++;
    if ({o_dout_valid, ov_dout, ov_dout_ch} !== {1'b1, 24'h0F0F0F, 2'd0}) begin
      failures++; $display("FAIL en_deliver: got dv=%b dout=%h ch=%0d required 1/0f0f0f/0",
                           o_dout_valid, ov_dout, ov_dout_ch);
    end
    cyc();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({ov_req_ready, o_busy} !== 5'b00000) begin
        failures++; $display("FAIL en_no_grant: cycle %0d got req=%b busy=%b required 0000/0", i, ov_req_ready, o_busy);
      end
      cyc();
    end
    $display("enable_drop: in-flight ch0 delivered, no grants while disabled");
  endtask

  task automatic test_reset_in_wait();
    i_en = 1'b1;
    #1;
    checks++;
    if (ov_req_ready !== 4'b0010) begin
      failures++; $display("FAIL rw_grant: got %b required 0010", ov_req_ready);
    end
    cyc();
    i_core_ready = 1'b1;
    cyc();
    i_core_ready = 1'b0;
    checks++;
    if (o_core_ready !== 1'b1) begin
      failures++; $display("FAIL rw_in_wait: got core_ready=%b required 1", o_core_ready);
    end
    i_rst_n = 1'b0; iv_core_dout = 24'hDEAD00; i_core_dout_valid = 1'b1;
    #1;
    check_all_zero("reset_in_wait");
    cyc();
    cyc();
    i_rst_n = 1'b1;
    #1;
    checks++;
    if ({ov_req_ready, o_dout_valid} !== 5'b00010) begin
      failures++; $display("FAIL rw_first_grant: got req=%b dv=%b required 0001/0", ov_req_ready, o_dout_valid);
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_dout_valid, o_core_din_valid, ov_core_din} !== {1'b0, 1'b1, words[0]}) begin
        failures++; $display("FAIL rw_no_stale: cycle %0d got dv=%b dinv=%b din=%h required 0/1/%h",
                             i, o_dout_valid, o_core_din_valid, ov_core_din, words[0]);
      end
      cyc();
    end
    i_rst_n = 1'b0; i_en = 1'b0; i_core_dout_valid = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    cyc();
    $display("reset_in_wait: outputs cleared, ch0 granted first, stale result dropped");
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int waits = 0;
    bit dv_seen = 1'b0;
    iv_req_valid = 4'b0011; i_en = 1'b1; i_core_ready = 1'b1; i_core_dout_valid = 1'b0; i_dout_ready = 1'b1;
    #1;
    checks++;
    if (ov_req_ready !== 4'b0001) begin
      failures++; $display("FAIL to_grant: got %b required 0001", ov_req_ready);
    end
    cyc();
    cyc();
    for (int i = 0; i < 40; i++) begin
      if (o_timeout === 1'b1) break;
      if (o_core_ready === 1'b1) waits++;
      if (o_dout_valid === 1'b1) dv_seen = 1'b1;
      cyc();
    end
    checks++;
    if ({o_timeout, ov_req_ready, dv_seen} !== {1'b1, 4'b0010, 1'b0} || waits != 16) begin
      failures++; $display("FAIL to_abort: got to=%b req=%b dv_seen=%b waits=%0d required 1/0010/0/16",
                           o_timeout, ov_req_ready, dv_seen, waits);
    end
    i_en = 1'b0;
    cyc();
    checks++;
    if ({o_busy, o_timeout} !== 2'b01) begin
      failures++; $display("FAIL to_sticky: got busy=%b to=%b required 0/1", o_busy, o_timeout);
    end
    $display("timeout: aborted after %0d wait cycles, next channel granted", waits);
  endtask
`else
  task automatic test_no_timeout();
    iv_req_valid = 4'b0011; i_en = 1'b1; i_core_ready = 1'b1; i_core_dout_valid = 1'b0; i_dout_ready = 1'b1;
    cyc();
    i_en = 1'b0;
    cyc();
    for (int i = 0; i < 40; i++) begin
      checks++;
      if ({o_core_ready, o_timeout, o_dout_valid} !== 3'b100) begin
        failures++; $display("FAIL nt_wait_hold: cycle %0d got crdy=%b to=%b dv=%b required 1/0/0",
                             i, o_core_ready, o_timeout, o_dout_valid);
      end
      cyc();
    end
    iv_core_dout = 24'h246801; i_core_dout_valid = 1'b1;
    cyc();
    i_core_dout_valid = 1'b0;
    checks++;
    if ({o_dout_valid, ov_dout, ov_dout_ch} !== {1'b1, 24'h246801, 2'd0}) begin
      failures++; $display("FAIL nt_deliver: got dv=%b dout=%h ch=%0d required 1/246801/0",
                           o_dout_valid, ov_dout, ov_dout_ch);
    end
    cyc();
    $display("no_timeout: wait held 40 cycles, then ch0 delivered");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_enable_drop();
    test_reset_in_wait();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global time limit reached");
  end

endmodule
